// File: rtl/tm_sr_pkg.sv
// rtl/tm_sr_pkg.sv - shared types and defaults for the TMIIa shift-register sequencer
package tm_sr_pkg;

  localparam int TM_SR_DATA_WIDTH = 170;
  localparam int TM_SR_CNT_WIDTH  = 8;
  localparam int TM_SR_DIV_WIDTH  = 8;

  // SHIFT_DIRECTION encoding
  localparam bit TM_SR_MSB_FIRST = 1'b1;
  localparam bit TM_SR_LSB_FIRST = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LOAD,
    S_FINISH
  } tm_sr_state_e;

endpackage

// File: rtl/tm_sr_tick.sv
// rtl/tm_sr_tick.sv - half-period down-counter; phase_end marks the last cycle of a phase
module tm_sr_tick
  import tm_sr_pkg::*;
#(
  parameter int DIV_WIDTH = TM_SR_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] half_m1,
  output logic                 phase_end
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Holds at zero once the phase has elapsed, so it never wraps mid-phase
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = half_m1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end = (cnt_q == '0);

endmodule

// File: rtl/tm_sr_seq_ctrl.sv
// rtl/tm_sr_seq_ctrl.sv - write/read-back sequencer for the TMIIa configuration shift register
module tm_sr_seq_ctrl
  import tm_sr_pkg::*;
#(
  parameter int DATA_WIDTH      = TM_SR_DATA_WIDTH,
  parameter int CNT_WIDTH       = TM_SR_CNT_WIDTH,
  parameter int DIV_WIDTH       = TM_SR_DIV_WIDTH,
  parameter bit SHIFT_DIRECTION = TM_SR_MSB_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic                  sr_data_in,
  output logic                  sr_clk,
  output logic                  sr_data_out,
  output logic                  sr_load,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  match,
  output logic                  match_valid
);

  tm_sr_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d, tx_cnt;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DATA_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d, prev_q, prev_d, dout_q, dout_d;
  logic [DATA_WIDTH-1:0] wr_shifted, rx_vec;
  logic                  sr_clk_q, sr_clk_d, sr_data_out_q, sr_data_out_d, sr_load_q, sr_load_d;
  logic                  busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic                  match_q, match_d, match_valid_q, match_valid_d;
  logic                  phase_end, tick_load, tick_clear, abort_take;

  // Serial bit n maps to word position n (LSB first) or DATA_WIDTH-1-n (MSB first)
  function automatic logic [CNT_WIDTH-1:0] bit_pos(input logic [CNT_WIDTH-1:0] cnt);
    bit_pos = SHIFT_DIRECTION ? CNT_WIDTH'(DATA_WIDTH - 1) - cnt : cnt;
  endfunction

  assign tx_cnt     = (state_q == S_LATCH) ? '0 : bit_cnt_q + CNT_WIDTH'(1);
  assign wr_shifted = wr_q >> bit_pos(tx_cnt);
  assign rx_vec     = DATA_WIDTH'(sr_data_in) << bit_pos(bit_cnt_q);
  assign abort_take = abort && (state_q != S_IDLE) && (state_q != S_FINISH);

  tm_sr_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .load      (tick_load),
    .clear     (tick_clear),
    .half_m1   (div_q),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    div_d         = div_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    prev_d        = prev_q;
    dout_d        = dout_q;
    sr_clk_d      = sr_clk_q;
    sr_data_out_d = sr_data_out_q;
    sr_load_d     = sr_load_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    match_d       = match_q;
    match_valid_d = match_valid_q;
    tick_load     = 1'b0;
    tick_clear    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_d    = din;
          div_d   = clk_div;
          busy_d  = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        sr_data_out_d = wr_shifted[0];
        bit_cnt_d     = '0;
        rd_d          = '0;
        tick_load     = 1'b1;
        state_d       = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (phase_end) begin
          sr_clk_d  = 1'b1;
          rd_d      = rd_q | rx_vec;
          tick_load = 1'b1;
          state_d   = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (phase_end) begin
          sr_clk_d  = 1'b0;
          tick_load = 1'b1;
          if (bit_cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
            sr_load_d = 1'b1;
            state_d   = S_LOAD;
          end else begin
            bit_cnt_d     = bit_cnt_q + CNT_WIDTH'(1);
            sr_data_out_d = wr_shifted[0];
            state_d       = S_SHIFT_LO;
          end
        end
      end
      S_LOAD: begin
        if (phase_end) begin
          sr_load_d = 1'b0;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d        = 1'b1;
        dout_d        = rd_q;
        match_d       = (rd_q == prev_q);
        match_valid_d = 1'b1;
        prev_d        = wr_q;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_take) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      aborted_d  = 1'b1;
      sr_clk_d   = 1'b0;
      sr_load_d  = 1'b0;
      tick_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      div_q         <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      prev_q        <= '0;
      dout_q        <= '0;
      sr_clk_q      <= 1'b0;
      sr_data_out_q <= 1'b0;
      sr_load_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      match_q       <= 1'b0;
      match_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      div_q         <= div_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      prev_q        <= prev_d;
      dout_q        <= dout_d;
      sr_clk_q      <= sr_clk_d;
      sr_data_out_q <= sr_data_out_d;
      sr_load_q     <= sr_load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
    end
  end

  assign sr_clk      = sr_clk_q;
  assign sr_data_out = sr_data_out_q;
  assign sr_load     = sr_load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign dout        = dout_q;
  assign match       = match_q;
  assign match_valid = match_valid_q;

endmodule

// File: tb/tb_tm_sr_seq_ctrl.sv
// tb/tb_tm_sr_seq_ctrl.sv - bench for tm_sr_seq_ctrl: MSB-first and LSB-first instances on 8-bit chip models
module tb_tm_sr_seq_ctrl;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: MSB-first instance, index 1: LSB-first instance
  logic       start_i[2], abort_i[2];
  logic [7:0] din_i[2], div_i[2];
  logic       sr_clk_o[2], sdo_o[2], load_o[2], busy_o[2], done_o[2], abrt_o[2], match_o[2], mv_o[2];
  logic [7:0] dout_o[2];

  logic [7:0] chip[2];
  logic       poke_en[2];
  logic [7:0] poke_val[2];
  logic       sclk_prev[2];
  logic       sdi0, sdi1;

  assign sdi0 = chip[0][7];
  assign sdi1 = chip[1][0];

  tm_sr_seq_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8), .DIV_WIDTH(8), .SHIFT_DIRECTION(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .start(start_i[0]), .abort(abort_i[0]), .din(din_i[0]), .clk_div(div_i[0]),
    .sr_data_in(sdi0), .sr_clk(sr_clk_o[0]), .sr_data_out(sdo_o[0]), .sr_load(load_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .aborted(abrt_o[0]), .dout(dout_o[0]),
    .match(match_o[0]), .match_valid(mv_o[0])
  );

  tm_sr_seq_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8), .DIV_WIDTH(8), .SHIFT_DIRECTION(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .start(start_i[1]), .abort(abort_i[1]), .din(din_i[1]), .clk_div(div_i[1]),
    .sr_data_in(sdi1), .sr_clk(sr_clk_o[1]), .sr_data_out(sdo_o[1]), .sr_load(load_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .aborted(abrt_o[1]), .dout(dout_o[1]),
    .match(match_o[1]), .match_valid(mv_o[1])
  );

  // Chip models: 8-bit shift registers that shift on each rising sr_clk
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (poke_en[d]) begin
        chip[d] <= poke_val[d];
      end else if (sr_clk_o[d] && !sclk_prev[d]) begin
        if (d == 0) chip[d] <= {chip[d][6:0], sdo_o[d]};
        else        chip[d] <= {sdo_o[d], chip[d][7:1]};
      end
      sclk_prev[d] <= sr_clk_o[d];
    end
  end

  // Pin monitor: pulse counts, phase lengths, data changes during sr_clk high
  int   load_cnt[2]    = '{0, 0};
  int   done_cnt[2]    = '{0, 0};
  int   load_run[2]    = '{0, 0};
  int   last_load[2]   = '{0, 0};
  int   hi_run[2]      = '{0, 0};
  int   last_hi[2]     = '{0, 0};
  int   lo_run[2]      = '{0, 0};
  int   last_lo[2]     = '{0, 0};
  int   glitch_cnt[2]  = '{0, 0};
  logic seen_hi[2]     = '{1'b0, 1'b0};
  logic sdo_prev[2]    = '{1'b0, 1'b0};
  logic sclk_mprev[2]  = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_o[d]) done_cnt[d] <= done_cnt[d] + 1;
      if (load_o[d]) begin
        load_run[d] <= load_run[d] + 1;
      end else if (load_run[d] != 0) begin
        last_load[d] <= load_run[d];
        load_cnt[d]  <= load_cnt[d] + 1;
        load_run[d]  <= 0;
      end
      if (sr_clk_o[d]) begin
        hi_run[d] <= hi_run[d] + 1;
        if (!sclk_mprev[d] && seen_hi[d] && lo_run[d] != 0) last_lo[d] <= lo_run[d];
        lo_run[d]  <= 0;
        seen_hi[d] <= 1'b1;
        if (sclk_mprev[d] && sdo_o[d] != sdo_prev[d]) glitch_cnt[d] <= glitch_cnt[d] + 1;
      end else begin
        if (hi_run[d] != 0) last_hi[d] <= hi_run[d];
        hi_run[d] <= 0;
        lo_run[d] <= lo_run[d] + 1;
        if (!busy_o[d]) seen_hi[d] <= 1'b0;
      end
      sdo_prev[d]   <= sdo_o[d];
      sclk_mprev[d] <= sr_clk_o[d];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] ref_chip[2];
  logic [7:0] ref_prev[2];
  logic [7:0] ref_dout[2];
  logic       ref_mv[2];

  task automatic ref_reset();
    for (int d = 0; d < 2; d++) begin
      ref_prev[d] = 8'h00;
      ref_dout[d] = 8'h00;
      ref_mv[d]   = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag, input int d);
    check_val(tag, int'({sr_clk_o[d], sdo_o[d], load_o[d], busy_o[d], done_o[d], abrt_o[d],
                         match_o[d], mv_o[d], dout_o[d]}), 0);
  endtask

  task automatic poke_chip(input int d, input logic [7:0] v);
    poke_en[d]  = 1'b1;
    poke_val[d] = v;
    @(posedge clk); #1;
    poke_en[d]  = 1'b0;
    ref_chip[d] = v;
  endtask

  // Called at #1 after a rising edge; abort_cyc is the edge index (start edge = 0) at which abort is sampled
  task automatic do_op(input int d, input bit poke, input logic [7:0] pval, input logic [7:0] wdata,
                       input logic [7:0] div, input int abort_cyc, input bit extra_start);
    int         h, exp_done, e, ld0, dn0, gl0;
    bit         got_done, got_abort, first_seen;
    logic [7:0] exp_dout;
    logic       exp_match, exp_first;
    h = int'(div) + 1;
    exp_done = 2 * h * NB + h + 2;
    if (poke) poke_chip(d, pval);
    exp_dout  = ref_chip[d];
    exp_match = (ref_chip[d] == ref_prev[d]);
    exp_first = (d == 0) ? wdata[7] : wdata[0];
    ld0 = load_cnt[d]; dn0 = done_cnt[d]; gl0 = glitch_cnt[d];
    got_done = 1'b0; got_abort = 1'b0; first_seen = 1'b0;

    din_i[d] = wdata; div_i[d] = div; start_i[d] = 1'b1; abort_i[d] = (abort_cyc == 0);
    @(posedge clk); #1;
    start_i[d] = 1'b0; abort_i[d] = 1'b0; e = 0;
    check_val("busy_rise", int'(busy_o[d]), 1);

    while (!got_done && !got_abort && e < exp_done + 20) begin
      start_i[d] = extra_start && (e + 1 == 3);
      abort_i[d] = (e + 1 == abort_cyc);
      @(posedge clk); #1;
      e++;
      got_done  = done_o[d];
      got_abort = abrt_o[d];
      if (!first_seen && sr_clk_o[d]) begin
        first_seen = 1'b1;
        check_val("first_bit", int'(sdo_o[d]), int'(exp_first));
      end
    end
    start_i[d] = 1'b0; abort_i[d] = 1'b0;

    if (abort_cyc >= 1 && abort_cyc < exp_done) begin
      check_val("abort_seen", int'(got_abort), 1);
      check_val("abort_edge", e, abort_cyc);
      check_val("abort_pins", int'({busy_o[d], sr_clk_o[d], load_o[d], done_o[d]}), 0);
      check_val("abort_dout", int'(dout_o[d]), int'(ref_dout[d]));
      check_val("abort_mv", int'(mv_o[d]), int'(ref_mv[d]));
      @(posedge clk); #1;
      check_val("abort_pulse", int'(abrt_o[d]), 0);
      check_val("abort_loads", load_cnt[d] - ld0, (abort_cyc >= 2 * h * NB + 2) ? 1 : 0);
    end else begin
      check_val("done_seen", int'(got_done), 1);
      check_val("done_edge", e, exp_done);
      check_val("done_busy", int'(busy_o[d]), 0);
      check_val("dout", int'(dout_o[d]), int'(exp_dout));
      check_val("match", int'(match_o[d]), int'(exp_match));
      check_val("match_valid", int'(mv_o[d]), 1);
      @(posedge clk); #1;
      check_val("done_pulse", int'(done_o[d]), 0);
      check_val("chip_written", int'(chip[d]), int'(wdata));
      check_val("load_pulses", load_cnt[d] - ld0, 1);
      check_val("load_len", last_load[d], h);
      check_val("hi_len", last_hi[d], h);
      check_val("lo_len", last_lo[d], h);
      check_val("sdo_stable", glitch_cnt[d] - gl0, 0);
      check_val("done_count", done_cnt[d] - dn0, 1);
      ref_prev[d] = wdata;
      ref_chip[d] = wdata;
      ref_dout[d] = exp_dout;
      ref_mv[d]   = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int         n, ld0, d, ac, h;
    logic [7:0] wv, pv, dv;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; abort_i[i] = 1'b0; din_i[i] = 8'h00; div_i[i] = 8'h00;
      poke_en[i] = 1'b1; poke_val[i] = 8'h00; ref_chip[i] = 8'h00;
    end
    ref_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_msb", 0);
    check_zero("reset_lsb", 1);
    rst = 1'b0;
    poke_en[0] = 1'b0; poke_en[1] = 1'b0;
    @(posedge clk); #1;

    // MSB-first directed sequence
    do_op(0, 1'b1, 8'h3C, 8'hA5, 8'd0, -1, 1'b0);
    do_op(0, 1'b0, 8'h00, 8'h5A, 8'd0, -1, 1'b0);
    do_op(0, 1'b1, 8'h5A ^ 8'h10, 8'hC3, 8'd0, -1, 1'b0);
    do_op(0, 1'b0, 8'h00, 8'h77, 8'd0, -1, 1'b1);
    do_op(0, 1'b0, 8'h00, 8'h11, 8'd0, 10, 1'b0);
    do_op(0, 1'b1, 8'h0F, 8'h22, 8'd0, -1, 1'b0);
    do_op(0, 1'b0, 8'h00, 8'h33, 8'd0, 0, 1'b0);
    do_op(0, 1'b0, 8'h00, 8'h44, 8'd1, 2 * 2 * NB + 2 + 2, 1'b0);

    // Reset while idle with match_valid set
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_zero("rst_idle_msb", 0);
    check_zero("rst_idle_lsb", 1);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_reset();

    // LSB-first with a 4-cycle half period
    do_op(1, 1'b1, 8'h81, 8'h3C, 8'd3, -1, 1'b0);
    do_op(1, 1'b0, 8'h00, 8'hC3, 8'd3, -1, 1'b0);

    // Reset while sr_clk is high
    poke_chip(0, 8'hC3);
    din_i[0] = 8'h96; div_i[0] = 8'd1; start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    ld0 = load_cnt[0];
    n = 0;
    while (!sr_clk_o[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("rst_reach_hi", int'(sr_clk_o[0]), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_zero("rst_mid_op", 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_no_load", load_cnt[0] - ld0, 0);
    do_op(0, 1'b1, 8'h5A, 8'hE1, 8'd1, -1, 1'b0);

    // Randomized operations on both instances
    for (int it = 0; it < 10; it++) begin
      d  = int'($urandom_range(0, 1));
      wv = 8'($urandom);
      pv = 8'($urandom);
      dv = 8'($urandom_range(0, 3));
      h  = int'(dv) + 1;
      ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * h * NB + h + 2)) : -1;
      do_op(d, 1'b1, pv, wv, dv, ac, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
